// File: rtl/ps2_host_tx.sv
// -----------------------------------------------------------------------------
// ps2_host_tx
//
// PS/2 host-to-device transmitter. Sends one command byte (for example 0xED
// set-LEDs or 0xFF reset) to the keyboard. The PS/2 clock and data lines are
// driven open-drain through the two *_oe outputs. While a transfer is in
// progress, pto_rx_inhibit tells the scan-code receiver to ignore line
// activity.
//
// Transfer sequence:
//   IDLE -> INHIBIT (clock held low) -> RTS (data low = start bit)
//        -> DATA (8 data bits, parity, stop) -> ACK -> WAIT_IDLE -> IDLE
// A single timeout counter bounds everything from RTS entry onward.
//
// Ports:
//   pti_clk          system clock (cpu_clk50)
//   pti_rst          synchronous reset, active-high
//   pti_data[7:0]    byte to send, sampled together with an accepted strobe
//   pti_wrn          active-low one-cycle write strobe, taken only when ready
//   pto_ready        1 = idle, a new byte can be accepted
//   pto_done         one-cycle pulse: transfer finished and the device acked
//   pto_ack_error    one-cycle pulse: transfer finished without an ack
//   pto_timeout      one-cycle pulse: transfer aborted by timeout
//   pto_rx_inhibit   1 while any transfer is in progress
//   pti_ps2_clk      sensed PS/2 clock line (asynchronous)
//   pti_ps2_data     sensed PS/2 data line (asynchronous)
//   pto_ps2_clk_oe   1 = pull the clock line low
//   pto_ps2_data_oe  1 = pull the data line low
// -----------------------------------------------------------------------------
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_LEN     = 4
) (
    input  logic       pti_clk,
    input  logic       pti_rst,
    input  logic [7:0] pti_data,
    input  logic       pti_wrn,
    output logic       pto_ready,
    output logic       pto_done,
    output logic       pto_ack_error,
    output logic       pto_timeout,
    output logic       pto_rx_inhibit,
    input  logic       pti_ps2_clk,
    input  logic       pti_ps2_data,
    output logic       pto_ps2_clk_oe,
    output logic       pto_ps2_data_oe
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FLT_W = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        DATA,
        ACK,
        WAIT_IDLE
    } state_t;

    // ---------------------------------------------------------------
    // Line conditioning: 2-FF synchronizer followed by a glitch filter
    // ---------------------------------------------------------------
    logic             ck_s1, ck_s2, dt_s1, dt_s2;
    logic             ck_f, dt_f, ck_fd;
    logic [FLT_W-1:0] ck_cnt, dt_cnt;
    logic             fe;

    always_ff @(posedge pti_clk) begin
        if (pti_rst) begin
            ck_s1  <= 1'b1;
            ck_s2  <= 1'b1;
            dt_s1  <= 1'b1;
            dt_s2  <= 1'b1;
            ck_f   <= 1'b1;
            dt_f   <= 1'b1;
            ck_fd  <= 1'b1;
            ck_cnt <= '0;
            dt_cnt <= '0;
        end else begin
            ck_s1 <= pti_ps2_clk;
            ck_s2 <= ck_s1;
            dt_s1 <= pti_ps2_data;
            dt_s2 <= dt_s1;
            ck_fd <= ck_f;

            // The counter tracks how many consecutive samples disagree with
            // the accepted level; any agreeing sample restarts it.
            if (ck_s2 == ck_f) begin
                ck_cnt <= '0;
            end else if (ck_cnt == FLT_W'(FILTER_LEN - 1)) begin
                ck_f   <= ck_s2;
                ck_cnt <= '0;
            end else begin
                ck_cnt <= ck_cnt + FLT_W'(1);
            end

            if (dt_s2 == dt_f) begin
                dt_cnt <= '0;
            end else if (dt_cnt == FLT_W'(FILTER_LEN - 1)) begin
                dt_f   <= dt_s2;
                dt_cnt <= '0;
            end else begin
                dt_cnt <= dt_cnt + FLT_W'(1);
            end
        end
    end

    assign fe = ck_fd & ~ck_f;

    // ---------------------------------------------------------------
    // Transfer FSM: state register and next-state/output logic
    // ---------------------------------------------------------------
    state_t           state_q, state_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [3:0]       fe_cnt_q, fe_cnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             par_q, par_d;
    logic             ack_ok_q, ack_ok_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             done_q, done_d;
    logic             ackerr_q, ackerr_d;
    logic             tmo_q, tmo_d;

    always_ff @(posedge pti_clk) begin
        if (pti_rst) begin
            state_q   <= IDLE;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            fe_cnt_q  <= '0;
            ack_ok_q  <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            ackerr_q  <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            inh_cnt_q <= inh_cnt_d;
            to_cnt_q  <= to_cnt_d;
            fe_cnt_q  <= fe_cnt_d;
            ack_ok_q  <= ack_ok_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            ackerr_q  <= ackerr_d;
            tmo_q     <= tmo_d;
        end
    end

    // Byte and parity are payload only; they are always rewritten on accept.
    always_ff @(posedge pti_clk) begin
        shreg_q <= shreg_d;
        par_q   <= par_d;
    end

    always_comb begin
        state_d   = state_q;
        inh_cnt_d = inh_cnt_q;
        to_cnt_d  = to_cnt_q;
        fe_cnt_d  = fe_cnt_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        ack_ok_d  = ack_ok_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        ackerr_d  = 1'b0;
        tmo_d     = 1'b0;

        case (state_q)
            IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (!pti_wrn) begin
                    shreg_d   = pti_data;
                    par_d     = ~^pti_data;
                    inh_cnt_d = '0;
                    fe_cnt_d  = '0;
                    clk_oe_d  = 1'b1;
                    state_d   = INHIBIT;
                end
            end

            INHIBIT: begin
                if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b1;
                    to_cnt_d  = '0;
                    state_d   = RTS;
                end else begin
                    inh_cnt_d = inh_cnt_q + INH_W'(1);
                end
            end

            default: begin
                // Timeout is checked first so it overrides any completion
                // event landing on the same cycle.
                if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    to_cnt_d  = '0;
                    fe_cnt_d  = '0;
                    tmo_d     = 1'b1;
                    state_d   = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    case (state_q)
                        RTS: begin
                            if (fe) begin
                                data_oe_d = ~shreg_q[0];
                                fe_cnt_d  = 4'd1;
                                state_d   = DATA;
                            end
                        end
                        DATA: begin
                            // fe_cnt_q holds how many falling edges have
                            // already been seen, so it indexes the next bit.
                            if (fe) begin
                                if (fe_cnt_q < 4'd8) begin
                                    data_oe_d = ~shreg_q[fe_cnt_q[2:0]];
                                    fe_cnt_d  = fe_cnt_q + 4'd1;
                                end else if (fe_cnt_q == 4'd8) begin
                                    data_oe_d = ~par_q;
                                    fe_cnt_d  = fe_cnt_q + 4'd1;
                                end else begin
                                    data_oe_d = 1'b0;
                                    state_d   = ACK;
                                end
                            end
                        end
                        ACK: begin
                            if (fe) begin
                                ack_ok_d = ~dt_f;
                                state_d  = WAIT_IDLE;
                            end
                        end
                        WAIT_IDLE: begin
                            if (ck_f && dt_f) begin
                                done_d   = ack_ok_q;
                                ackerr_d = ~ack_ok_q;
                                fe_cnt_d = '0;
                                state_d  = IDLE;
                            end
                        end
                        default: begin
                            state_d = IDLE;
                        end
                    endcase
                end
            end
        endcase
    end

    assign pto_ready       = (state_q == IDLE);
    assign pto_rx_inhibit  = (state_q != IDLE);
    assign pto_done        = done_q;
    assign pto_ack_error   = ackerr_q;
    assign pto_timeout     = tmo_q;
    assign pto_ps2_clk_oe  = clk_oe_q;
    assign pto_ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// -----------------------------------------------------------------------------
// tb_ps2_host_tx
//
// Directed and randomized bench for ps2_host_tx. A behavioural PS/2 device
// drives the open-drain lines (40-cycle half periods), records the bit seen
// on the data line at each falling edge, and optionally acks. Expected line
// frames are built from the byte with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int TMO = 2000;
    localparam int FLT = 4;

    logic       clk = 1'b0;
    logic       pti_rst;
    logic [7:0] pti_data;
    logic       pti_wrn;
    logic       pto_ready, pto_done, pto_ack_error, pto_timeout, pto_rx_inhibit;
    logic       pto_ps2_clk_oe, pto_ps2_data_oe;
    logic       dev_clk_low, dev_data_low;
    logic       ps2_clk_line, ps2_data_line;

    // Open-drain wired-AND of host and device drivers.
    assign ps2_clk_line  = ~(dev_clk_low  | pto_ps2_clk_oe);
    assign ps2_data_line = ~(dev_data_low | pto_ps2_data_oe);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .FILTER_LEN    (FLT)
    ) dut (
        .pti_clk        (clk),
        .pti_rst        (pti_rst),
        .pti_data       (pti_data),
        .pti_wrn        (pti_wrn),
        .pto_ready      (pto_ready),
        .pto_done       (pto_done),
        .pto_ack_error  (pto_ack_error),
        .pto_timeout    (pto_timeout),
        .pto_rx_inhibit (pto_rx_inhibit),
        .pti_ps2_clk    (ps2_clk_line),
        .pti_ps2_data   (ps2_data_line),
        .pto_ps2_clk_oe (pto_ps2_clk_oe),
        .pto_ps2_data_oe(pto_ps2_data_oe)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Status pulse monitor.
    int c_done = 0;
    int c_aerr = 0;
    int c_tmo  = 0;
    int c_multi = 0;
    always @(negedge clk) begin
        c_done = c_done + int'(pto_done);
        c_aerr = c_aerr + int'(pto_ack_error);
        c_tmo  = c_tmo + int'(pto_timeout);
        if ((int'(pto_done) + int'(pto_ack_error) + int'(pto_timeout)) > 1)
            c_multi = c_multi + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference frame as seen on the line at fe #1..#10: data LSB first,
    // odd parity, stop bit 1.
    function automatic logic [9:0] frame_of(input logic [7:0] b);
        logic par;
        par = (($countones(b) % 2) == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, b};
    endfunction

    task automatic strobe(input logic [7:0] b, input string tag);
        int n;
        n = 0;
        while (!pto_ready && n < 3000) begin
            tick(1);
            n++;
        end
        check({tag, " ready before strobe"}, 32'(pto_ready), 32'd1);
        pti_data = b;
        pti_wrn  = 1'b0;
        tick(1);
        pti_wrn  = 1'b1;
        pti_data = 8'h00;
    endtask

    // Device side of one transfer. abort_k > 0 stops right after fe #abort_k
    // with the clock still held low.
    task automatic device_xfer(input bit do_ack, input int glitch_k, input int abort_k,
                               output logic [9:0] bits, output bit ok);
        int n;
        bits = '0;
        ok   = 1'b0;
        n    = 0;
        while (!(pto_ps2_data_oe && !pto_ps2_clk_oe) && n < 200) begin
            tick(1);
            n++;
        end
        if (n >= 200) return;
        tick(10);
        for (int k = 1; k <= 11; k++) begin
            if (k == 11 && do_ack) dev_data_low = 1'b1;
            if (k == glitch_k) begin
                tick(10);
                dev_clk_low = 1'b1;
                tick(3);
                dev_clk_low = 1'b0;
                pti_data = 8'h55;
                pti_wrn  = 1'b0;
                tick(1);
                pti_wrn  = 1'b1;
                pti_data = 8'h00;
                tick(26);
            end else begin
                tick(40);
            end
            dev_clk_low = 1'b1;
            if (k == abort_k) begin
                tick(10);
                ok = 1'b1;
                return;
            end
            tick(40);
            if (k <= 10) bits[k-1] = ps2_data_line;
            dev_clk_low = 1'b0;
        end
        dev_data_low = 1'b0;
        ok = 1'b1;
    endtask

    task automatic do_send(input logic [7:0] b, input bit do_ack, input int glitch_k,
                           input string tag);
        int n, d0, e0, t0;
        logic [9:0] bits;
        bit ok;
        strobe(b, tag);
        check({tag, " clk_oe 1 cycle after strobe"}, 32'(pto_ps2_clk_oe), 32'd1);
        check({tag, " ready low after strobe"}, 32'(pto_ready), 32'd0);
        n = 0;
        while (pto_ps2_clk_oe && !pto_ps2_data_oe && n < 100) begin
            tick(1);
            n++;
        end
        check({tag, " inhibit length"}, 32'(n), 32'(INH));
        check({tag, " rts oe {clk,data}"}, 32'({pto_ps2_clk_oe, pto_ps2_data_oe}), 32'd1);
        d0 = c_done;
        e0 = c_aerr;
        t0 = c_tmo;
        device_xfer(do_ack, glitch_k, 0, bits, ok);
        check({tag, " device saw RTS"}, 32'(ok), 32'd1);
        check({tag, " line bits fe1..fe10"}, 32'(bits), 32'(frame_of(b)));
        n = 0;
        while (!pto_ready && n < 200) begin
            tick(1);
            n++;
        end
        tick(1);
        check({tag, " ready after transfer"}, 32'(pto_ready), 32'd1);
        check({tag, " rx_inhibit after transfer"}, 32'(pto_rx_inhibit), 32'd0);
        check({tag, " done pulses"}, 32'(c_done - d0), do_ack ? 32'd1 : 32'd0);
        check({tag, " ack_error pulses"}, 32'(c_aerr - e0), do_ack ? 32'd0 : 32'd1);
        check({tag, " timeout pulses"}, 32'(c_tmo - t0), 32'd0);
    endtask

    initial begin
        int n, d0, e0, t0;
        logic [9:0] bits;
        bit ok;
        logic [7:0] rb;
        bit rack;

        pti_rst      = 1'b1;
        pti_wrn      = 1'b1;
        pti_data     = 8'h00;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        tick(3);
        pti_rst = 1'b0;
        tick(1);

        // Reset state
        check("reset ready", 32'(pto_ready), 32'd1);
        check("reset rx_inhibit", 32'(pto_rx_inhibit), 32'd0);
        check("reset oe {clk,data}", 32'({pto_ps2_clk_oe, pto_ps2_data_oe}), 32'd0);
        check("reset status", 32'({pto_done, pto_ack_error, pto_timeout}), 32'd0);
        tick(10);

        // 0xED acked
        do_send(8'hED, 1'b1, 0, "ed_ack");
        tick(20);

        // 0x00 not acked
        do_send(8'h00, 1'b0, 0, "00_nack");
        tick(20);

        // 0xFF, device never clocks -> timeout
        strobe(8'hFF, "ff_tmo");
        n = 0;
        while (!pto_ps2_data_oe && n < 100) begin
            tick(1);
            n++;
        end
        check("ff_tmo reached RTS", 32'(pto_ps2_data_oe), 32'd1);
        t0 = c_tmo;
        d0 = c_done;
        e0 = c_aerr;
        n = 0;
        while (!pto_timeout && n < 3000) begin
            tick(1);
            n++;
        end
        check("ff_tmo cycles from RTS", 32'(n), 32'(TMO));
        check("ff_tmo oe {clk,data}", 32'({pto_ps2_clk_oe, pto_ps2_data_oe}), 32'd0);
        check("ff_tmo ready (IDLE)", 32'(pto_ready), 32'd1);
        check("ff_tmo rx_inhibit", 32'(pto_rx_inhibit), 32'd0);
        tick(3);
        check("ff_tmo timeout pulses", 32'(c_tmo - t0), 32'd1);
        check("ff_tmo other pulses", 32'((c_done - d0) + (c_aerr - e0)), 32'd0);
        tick(20);

        // Clock glitch and ignored second strobe during DATA
        do_send(8'hA3, 1'b1, 4, "glitch");
        tick(20);

        // Reset after fe #5
        strobe(8'h3C, "rst_mid");
        device_xfer(1'b1, 0, 5, bits, ok);
        check("rst_mid device saw RTS", 32'(ok), 32'd1);
        d0 = c_done;
        e0 = c_aerr;
        t0 = c_tmo;
        pti_rst = 1'b1;
        tick(1);
        pti_rst = 1'b0;
        check("rst_mid oe {clk,data}", 32'({pto_ps2_clk_oe, pto_ps2_data_oe}), 32'd0);
        check("rst_mid ready", 32'(pto_ready), 32'd1);
        check("rst_mid rx_inhibit", 32'(pto_rx_inhibit), 32'd0);
        tick(20);
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        tick(100);
        check("rst_mid status pulses", 32'((c_done - d0) + (c_aerr - e0) + (c_tmo - t0)), 32'd0);
        check("rst_mid still idle", 32'(pto_ready), 32'd1);
        do_send(8'hF4, 1'b1, 0, "f4_after_rst");
        tick(20);

        // Randomized bytes and ack decisions
        for (int i = 0; i < 4; i++) begin
            rb   = 8'($urandom_range(0, 255));
            rack = 1'($urandom_range(0, 1));
            do_send(rb, rack, 0, $sformatf("rand%0d_%02h_ack%0d", i, rb, rack));
            tick(int'($urandom_range(5, 30)));
        end

        check("status pulses mutually exclusive", 32'(c_multi), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. Sends command bytes to the keyboard (e.g. 0xED set-LEDs, 0xFF reset); it is the host-side counterpart of the keyboard scan-code receiver.
- Sits on cpu_clk50 beside the keyboard block. The mem stage drives it through a write strobe and a ready flag, in the same way it drives the UART.
- Drives the PS/2 clock and data lines open-drain, and tells the receiver to ignore line activity while a transfer is in progress.

Parameters:
- INHIBIT_CYCLES, 5000: cycles the PS/2 clock is held low before request-to-send (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000: maximum cycles from the start of request-to-send to the end of the ack phase (15 ms).
- FILTER_LEN, 4: consecutive identical synchronized samples required before a PS/2 line level change is accepted.

Ports:
- pti_clk  in  1  system clock (cpu_clk50).
- pti_rst  in  1  synchronous reset, active-high.
- pti_data  in  8  byte to transmit; sampled with the accepted strobe.
- pti_wrn  in  1  active-low write strobe, one cycle wide; accepted only when pto_ready=1.
- pto_ready  out  1  1 = idle, a new byte can be accepted.
- pto_done  out  1  one-cycle pulse: transfer ended and the device acked.
- pto_ack_error  out  1  one-cycle pulse: transfer ended but no ack was received (data high at the ack edge).
- pto_timeout  out  1  one-cycle pulse: transfer aborted by timeout.
- pto_rx_inhibit  out  1  1 whenever the state is not IDLE; the keyboard receiver discards bits while it is high.
- pti_ps2_clk  in  1  sensed PS/2 clock line (asynchronous).
- pti_ps2_data  in  1  sensed PS/2 data line (asynchronous).
- pto_ps2_clk_oe  out  1  1 = pull the clock line low, 0 = release it.
- pto_ps2_data_oe  out  1  1 = pull the data line low, 0 = release it.

Behaviour:
- Reset (pti_rst=1 at a clock edge), including in the middle of a transfer:
  - State goes to IDLE; all counters clear.
  - Both oe outputs are 0 (lines released) from the next edge.
  - pto_ready=1; pto_done, pto_ack_error and pto_timeout are 0; pto_rx_inhibit=0.
  - Synchronizers and filters are preset to 1.
- Input conditioning:
  - Each line passes through a 2-FF synchronizer, then a filter.
  - The filtered level changes only after FILTER_LEN consecutive equal samples.
  - A falling edge (fe) is a filtered clock transition from 1 to 0; it lasts one cycle.
- Parity: odd parity, par = ~^data. The byte is latched into a shift register when the strobe is accepted.
- IDLE: pti_wrn=0 latches the byte, sets pto_ready=0 on the next cycle, and moves to INHIBIT.
- INHIBIT:
  - clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles.
  - Then moves to RTS and clears the timeout counter.
- RTS:
  - data_oe=1 (start bit 0), clk_oe=0.
  - Waits for fe #1, then moves to DATA.
- DATA:
  - At fe #1 through #8, data_oe is set to ~bit[k-1], LSB first.
  - At fe #9, data_oe is set to ~par.
  - At fe #10, data_oe=0 (stop bit 1); the state moves to ACK.
- ACK:
  - At fe #11, the filtered data line is sampled: 0 = ack, 1 = error.
  - The state moves to WAIT_IDLE.
- WAIT_IDLE:
  - Waits until the filtered clock and data lines are both 1.
  - Then returns to IDLE, sets pto_ready=1, and pulses pto_done or pto_ack_error on the same cycle as the IDLE entry.
- Timeout:
  - The counter runs in RTS, DATA, ACK and WAIT_IDLE.
  - When it reaches TIMEOUT_CYCLES: both oe outputs go to 0, pto_timeout pulses, and the state returns to IDLE.
  - If the timeout and a completing event occur on the same cycle, the timeout wins.
- Strobe priority and bit timing:
  - pti_wrn=0 while pto_ready=0 is ignored; the in-flight byte is unaffected.
  - A strobe on the same cycle as the return to IDLE is also ignored; the accepting cycle must have pto_ready=1.
  - Data changes only on falling edges, so the device samples a stable bit on the rising edge.
- Latency: strobe to clk_oe=1 is 1 cycle. The INHIBIT phase is exactly INHIBIT_CYCLES.
- Status pulses are mutually exclusive, each exactly one cycle wide.

Test Plan:
All scenarios use INHIBIT_CYCLES=20, TIMEOUT_CYCLES=2000, FILTER_LEN=4. The device model clocks at 40-cycle half periods and acks.
- Send 0xED with the device acking:
  - clk_oe=1 for exactly 20 cycles, then data_oe=1.
  - Bits driven on the line at fe #1..#10: 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - Device ack at fe #11 produces a single pto_done pulse; pto_ready returns to 1.
- Send 0x00 with the device not acking (data high at fe #11): line sequence is all 0, parity 1, stop 1; pto_ack_error pulses and pto_done stays 0.
- Strobe 0xFF with the device never clocking: exactly 2000 cycles after RTS entry, pto_timeout pulses, both oe outputs go to 0, and the state is IDLE.
- During DATA, apply a 3-cycle clock glitch low followed by a second strobe of 0x55: the glitch is ignored (no bit advance), the strobe is ignored, and the original byte completes correctly.
- Assert pti_rst for 1 cycle after fe #5: on the next cycle both oe outputs are 0, pto_ready=1, pto_rx_inhibit=0, and no status pulse occurs. A new send of 0xF4 then completes with pto_done.
